// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the hazard controller and the stages.
// The master (pipe_ctrl) receives the hazard, busy and redirect requests
// and drives the per-register stall/flush vectors and the PC redirect.
// The slave side is used by the pipeline stages, or by a testbench.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  // requests from the stages
  logic              id_load_use;
  logic              ex_busy;
  logic              mem_busy;
  logic              ex_branch_taken;
  logic [ADDR_W-1:0] ex_branch_target;
  logic              wb_except_valid;
  logic [ADDR_W-1:0] except_entry;
  logic              wb_ertn_valid;
  logic [ADDR_W-1:0] ertn_era;
  // controls back to the stages
  logic              pc_stall;
  logic [3:0]        stall;
  logic [3:0]        flush;
  logic              mem_cancel;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              drain_active;

  modport master (
    input  id_load_use, ex_busy, mem_busy, ex_branch_taken, ex_branch_target,
           wb_except_valid, except_entry, wb_ertn_valid, ertn_era,
    output pc_stall, stall, flush, mem_cancel, redirect_valid, redirect_pc,
           drain_active
  );

  modport slave (
    output id_load_use, ex_busy, mem_busy, ex_branch_taken, ex_branch_target,
           wb_except_valid, except_entry, wb_ertn_valid, ertn_era,
    input  pc_stall, stall, flush, mem_cancel, redirect_valid, redirect_pc,
           drain_active
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline hazard controller.
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   bus           pipe_ctrl_if.master: hazard requests in, stall/flush/redirect out
//   stall_cnt     cycles with pc_stall=1 (wraps)
//   redirect_cnt  redirect events (wraps)
// Stall/flush/redirect are combinational from the inputs and the state.
// After every redirect a DRAIN phase holds flush for FLUSH_CYCLES cycles
// so stale fetch responses are discarded.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [3:0]       drain_left_q, drain_left_d;
  logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      drain_left_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_left_q <= drain_left_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d      = state_q;
    drain_left_d = drain_left_q;
    if (state_q == DRAIN) begin
      drain_left_d = drain_left_q - 4'd1;
      if (drain_left_q == 4'd1) state_d = IDLE;
    end else begin
      // a branch only redirects when no busy unit outranks it
      if (bus.wb_except_valid || bus.wb_ertn_valid ||
          (bus.ex_branch_taken && !bus.mem_busy && !bus.ex_busy)) begin
        state_d      = DRAIN;
        drain_left_d = 4'(FLUSH_CYCLES);
      end
    end
  end

  // output logic
  always_comb begin
    bus.pc_stall       = 1'b0;
    bus.stall          = '0;
    bus.flush          = '0;
    bus.mem_cancel     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.drain_active   = 1'b0;
    if (!rst) begin
      bus.flush = '1;
    end else if (state_q == DRAIN) begin
      bus.flush        = '1;
      bus.mem_cancel   = 1'b1;
      bus.drain_active = 1'b1;
    end else if (bus.wb_except_valid) begin
      bus.flush          = '1;
      bus.mem_cancel     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = bus.except_entry;
    end else if (bus.wb_ertn_valid) begin
      bus.flush          = '1;
      bus.mem_cancel     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = bus.ertn_era;
    end else if (bus.mem_busy) begin
      bus.pc_stall = 1'b1;
      bus.stall    = 4'b0111;
      bus.flush    = 4'b1000;
    end else if (bus.ex_busy) begin
      bus.pc_stall = 1'b1;
      bus.stall    = 4'b0011;
      bus.flush    = 4'b0100;
    end else if (bus.ex_branch_taken) begin
      bus.flush          = 4'b0011;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = bus.ex_branch_target;
    end else if (bus.id_load_use) begin
      bus.pc_stall = 1'b1;
      bus.stall    = 4'b0001;
      bus.flush    = 4'b0010;
    end
  end

  // performance counters, wrap modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (bus.pc_stall)       stall_cnt_q    <= stall_cnt_q + 1'b1;
      if (bus.redirect_valid) redirect_cnt_q <= redirect_cnt_q + 1'b1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline hazard controller. It is the driving end of the stall/flush/valid interface that every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) consumes. It turns hazard, busy and redirect requests from the stages into per-register stall/flush vectors and a PC redirect. A post-redirect drain FSM discards stale in-flight fetch responses.

Parameters:
ADDR_W, 32, PC / redirect address width
FLUSH_CYCLES, 2, cycles flush is held after a redirect event (fetch pipeline depth); legal range 1..15
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_load_use  in  1  ID source depends on a load currently in EX
ex_busy  in  1  multi-cycle EX unit (mul/div) not done
mem_busy  in  1  dcache miss / LSU not done
ex_branch_taken  in  1  EX resolved a mispredicted or taken branch
ex_branch_target  in  ADDR_W  branch target
wb_except_valid  in  1  exception committed at WB
except_entry  in  ADDR_W  exception entry (CSR EENTRY)
wb_ertn_valid  in  1  ERTN committed at WB
ertn_era  in  ADDR_W  return address (CSR ERA)
pc_stall  out  1  hold PC
stall  out  4  per-register stall; bit0=IF_ID, 1=ID_EX, 2=EX_MEM, 3=MEM_WB
flush  out  4  per-register flush, same bit order
mem_cancel  out  1  abort outstanding LSU request
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  ADDR_W  redirect target
drain_active  out  1  FSM in DRAIN
stall_cnt  out  CNT_W  cycles with pc_stall=1
redirect_cnt  out  CNT_W  redirect events

Behaviour:
- FSM states: IDLE and DRAIN. Down-counter drain_left has 4 bits.
- Reset (rst=0, async): state=IDLE, drain_left=0, both counters=0. While in reset: flush=4'b1111, stall=0, pc_stall=0, redirect_valid=0, mem_cancel=0, redirect_pc=0.
- All stall/flush/redirect outputs are combinational from the inputs and the state (0-cycle latency). Only the FSM and the counters are registered.
- IDLE, one event per cycle, resolved in strict priority order (highest first):
  1. wb_except_valid: flush=1111, stall=0, pc_stall=0, mem_cancel=1, redirect_valid=1, redirect_pc=except_entry. Next state DRAIN.
  2. wb_ertn_valid: same as 1 but redirect_pc=ertn_era.
  3. mem_busy: pc_stall=1, stall=0111, flush=1000 (bubble into WB). Branch and load-use are ignored.
  4. ex_busy: pc_stall=1, stall=0011, flush=0100. Branch is ignored; EX holds the branch and re-presents it later.
  5. ex_branch_taken: flush=0011, stall=0, pc_stall=0, redirect_valid=1, redirect_pc=ex_branch_target. Next state DRAIN. A simultaneous id_load_use is ignored (ID holds a wrong-path instruction).
  6. id_load_use: pc_stall=1, stall=0001, flush=0010.
  7. None: all outputs 0.
- On entering DRAIN: drain_left=FLUSH_CYCLES.
- DRAIN: flush=1111, stall=0, pc_stall=0, redirect_valid=0, mem_cancel=1, drain_active=1. All inputs are ignored. drain_left decrements each cycle; on the cycle it reads 1, next state is IDLE. So flush is held exactly FLUSH_CYCLES cycles after the event cycle.
- An exception or ERTN arriving while mem_busy or ex_busy is high: the exception wins (priority above).
- redirect_pc is 0 whenever redirect_valid=0.
- stall_cnt increments by 1 on each cycle with pc_stall=1.
- redirect_cnt increments by 1 on each cycle with redirect_valid=1.
- Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-DRAIN: immediate return to IDLE, counters cleared.
- Reset deasserted: first active edge behaves as IDLE with no history.

Test Plan:
- Reset: rst=0 async mid-cycle -> flush=1111, pc_stall=0, counters=0. Release with all inputs 0 -> all outputs 0 on the next cycle.
- Load-use: id_load_use=1 for 1 cycle -> pc_stall=1, stall=0001, flush=0010 that cycle; stall_cnt=1.
- Branch with FLUSH_CYCLES=2: ex_branch_taken=1, target=0x1c000040 -> same cycle redirect_valid=1, redirect_pc=0x1c000040, flush=0011. Next 2 cycles flush=1111, drain_active=1. Then IDLE. redirect_cnt=1.
- Busy vs. branch: mem_busy=1 and ex_branch_taken=1 for 3 cycles, then mem_busy=0 -> 3 cycles stall=0111, flush=1000, no redirect. Redirect fires in cycle 4.
- Exception beats busy: wb_except_valid=1, mem_busy=1, except_entry=0x1c008000 -> flush=1111, mem_cancel=1, redirect_pc=0x1c008000. wb_ertn_valid in the following DRAIN cycle is ignored.
- Counter wrap with CNT_W=4: hold id_load_use for 17 cycles -> stall_cnt=1.
